monitor_graph_loader: RTL and testbench
=======================================

MONITOR_GRAPH_LOADER -- requirements
Module: monitor_graph_loader

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sets the number of buffered host write entries (power of two).
REQ-002 Parameter ACK_TIMEOUT, default 255, sets the maximum number of WRITE-state cycles allowed before mem_wr_ack.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: reset is asynchronous and active-low.
REQ-005 Port host_wr_valid, input, 1: host presents one graph word.
REQ-006 Port host_wr_ready, output, 1: the loader can accept a word (FIFO not full).
REQ-007 Port host_wr_addr, input, 12: target monitor-memory address.
REQ-008 Port host_wr_data, input, 32: graph word, carrying state bits [31:28], next-state field [27:16] and valid-bit mask [15:0].
REQ-009 Port mon_busy, input, 1: monitor is mid-packet; no new write may start.
REQ-010 Port mem_we, output, 1: write strobe to the monitor memory port.
REQ-011 Port mem_addr, output, 12: write address.
REQ-012 Port mem_din, output, 32: write data.
REQ-013 Port mem_wr_ack, input, 1: monitor write acknowledge.
REQ-014 Port err_clr, input, 1: clears timeout_err.
REQ-015 Port timeout_err, output, 1: sticky flag; an acknowledge timed out.
REQ-016 Port load_count, output, 16: number of acknowledged writes.
REQ-017 Port fifo_level, output, 3: current FIFO occupancy.
REQ-018 Port loader_idle, output, 1: FSM is in IDLE and the FIFO is empty.

Function
REQ-019 A push SHALL occur when host_wr_valid && host_wr_ready at a clock edge; host_wr_valid while host_wr_ready=0 SHALL be ignored with no side effect.
REQ-020 host_wr_ready SHALL be 0 exactly when fifo_level==FIFO_DEPTH, and is combinational from fifo_level.
REQ-021 A simultaneous push and pop SHALL leave fifo_level unchanged and preserve FIFO order.
REQ-022 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 The FSM SHALL have two states, IDLE and WRITE.
REQ-024 IDLE->WRITE SHALL occur when fifo_level!=0 && mon_busy==0.
- On that edge mem_addr/mem_din load from the FIFO head, mem_we goes 1 and the timer clears.
- A word pushed at edge N into an empty FIFO with mon_busy=0 SHALL therefore show mem_we=1 after edge N+1.
REQ-025 In WRITE, mem_we, mem_addr and mem_din SHALL stay constant until exit.
- mem_wr_ack is sampled only in WRITE; an ack in IDLE SHALL be ignored.
REQ-026 WRITE with mem_wr_ack=1 SHALL produce the following on the same edge:
- pop the head entry;
- load_count +1, wrapping 0xFFFF->0x0000;
- mem_we->0;
- next state IDLE.
REQ-027 WRITE without ack SHALL increment the 8-bit timer each cycle.
REQ-028 When the timer equals ACK_TIMEOUT-1 and mem_wr_ack=0, the next edge SHALL produce the following:
- pop and discard the entry;
- timeout_err->1;
- mem_we->0;
- next state IDLE;
- load_count unchanged.
REQ-029 An ack arriving in the timeout cycle SHALL win: the write counts as acknowledged and timeout_err is not set.
REQ-030 mon_busy rising during WRITE SHALL NOT abort the write in progress.
REQ-031 Back-to-back writes SHALL have at least one IDLE cycle with mem_we=0 between them.
REQ-032 err_clr SHALL clear timeout_err on the next edge; if a timeout occurs in the same cycle, set SHALL dominate.
REQ-033 mem_addr and mem_din SHALL hold their last values in IDLE.

Reset
REQ-034 Asserting reset (low) SHALL immediately, without a clock, force all of the following:
- FSM to IDLE, FIFO empty, pointers and timer to 0;
- mem_we=0, mem_addr=0, mem_din=0;
- load_count=0, timeout_err=0, fifo_level=0;
- host_wr_ready=1, loader_idle=1.
REQ-035 Reset during WRITE SHALL drop mem_we and all buffered entries, and SHALL emit no ack-driven count.
REQ-036 After reset deasserts, the first clock edge SHALL behave as a normal IDLE cycle.

Verification
REQ-037 Single write: push addr 0x3B5, data 0x2005_0013, mon_busy=0, ack 3 cycles after mem_we -> mem_we asserted 1 cycle after the push; the write is presented exactly once; load_count=1; loader_idle=1.
REQ-038 Full FIFO: push 5 words with the ack held low and mon_busy=1 -> host_wr_ready=0 after 4 pushes; fifo_level=4; the 5th word is never written; releasing mon_busy with immediate acks -> addresses emitted in push order.
REQ-039 Timeout: with ACK_TIMEOUT=255 and no ack -> mem_we high 255 cycles, then timeout_err=1, fifo_level decremented, load_count unchanged; err_clr pulse -> timeout_err=0.
REQ-040 Ack in the timeout cycle -> load_count +1 and timeout_err stays 0.
REQ-041 Gating: mon_busy=1 with 2 entries queued -> no mem_we; mon_busy->0 -> 2 writes, each separated by an idle cycle; mon_busy->1 mid-write -> the current write completes.
REQ-042 Reset mid-WRITE with 3 entries queued -> mem_we=0 asynchronously; fifo_level=0; no writes after release until a new push.

Source files
------------

// File: rtl/monitor_graph_loader.sv
// monitor_graph_loader: buffers host graph words in a FIFO and writes them to monitor memory
// one at a time, with acknowledge timeout detection and gating while the monitor is busy.
module monitor_graph_loader #(
   parameter int FIFO_DEPTH  = 4,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        host_wr_valid,
   output logic        host_wr_ready,
   input  logic [11:0] host_wr_addr,
   input  logic [31:0] host_wr_data,
   input  logic        mon_busy,
   output logic        mem_we,
   output logic [11:0] mem_addr,
   output logic [31:0] mem_din,
   input  logic        mem_wr_ack,
   input  logic        err_clr,
   output logic        timeout_err,
   output logic [15:0] load_count,
   output logic [2:0]  fifo_level,
   output logic        loader_idle
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH + 1);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] WRITE = 1'b1;
   localparam logic [7:0] TMAX  = 8'(ACK_TIMEOUT - 1);

   logic [11:0]   addr_mem [FIFO_DEPTH];
   logic [31:0]   data_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [0:0]    state_q, state_d;
   logic [7:0]    timer_q, timer_d;
   logic [11:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   mem_din_q, mem_din_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          push, pop, ack_hit, tmo, start;

   // An ack in the timeout cycle wins, so the timeout term requires no ack.
   always_comb begin
      push       = host_wr_valid && host_wr_ready;
      ack_hit    = (state_q == WRITE) && mem_wr_ack;
      tmo        = (state_q == WRITE) && !mem_wr_ack && (timer_q == TMAX);
      pop        = ack_hit || tmo;
      start      = (state_q == IDLE) && (level_q != '0) && !mon_busy;
      state_d    = start ? WRITE : pop ? IDLE : state_q;
      timer_d    = start ? 8'd0 : (state_q == WRITE) ? timer_q + 8'd1 : timer_q;
      level_d    = level_q + LW'(push) - LW'(pop);
      wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      mem_addr_d = start ? addr_mem[rd_ptr_q] : mem_addr_q;
      mem_din_d  = start ? data_mem[rd_ptr_q] : mem_din_q;
      cnt_d      = ack_hit ? cnt_q + 16'd1 : cnt_q;
      err_d      = tmo ? 1'b1 : err_clr ? 1'b0 : err_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         level_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         level_q    <= level_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and level.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= host_wr_addr;
         data_mem[wr_ptr_q] <= host_wr_data;
      end
   end

   assign host_wr_ready = level_q != LW'(FIFO_DEPTH);
   assign mem_we        = state_q == WRITE;
   assign mem_addr      = mem_addr_q;
   assign mem_din       = mem_din_q;
   assign load_count    = cnt_q;
   assign timeout_err   = err_q;
   assign fifo_level    = 3'(level_q);
   assign loader_idle   = (state_q == IDLE) && (level_q == '0);
endmodule

// File: tb/tb_monitor_graph_loader.sv
// tb_monitor_graph_loader: directed scenario tests for monitor_graph_loader with inline checks.
module tb_monitor_graph_loader;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        host_wr_valid = 1'b0;
   logic        host_wr_ready;
   logic [11:0] host_wr_addr = '0;
   logic [31:0] host_wr_data = '0;
   logic        mon_busy = 1'b0;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_din;
   logic        mem_wr_ack = 1'b0;
   logic        err_clr = 1'b0;
   logic        timeout_err;
   logic [15:0] load_count;
   logic [2:0]  fifo_level;
   logic        loader_idle;
   int          total = 0;
   int          bad = 0;
   logic [11:0] wq[$];
   logic        we_prev = 1'b0;

   monitor_graph_loader dut (
      .clk(clk), .reset(reset), .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
      .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data), .mon_busy(mon_busy),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_wr_ack(mem_wr_ack),
      .err_clr(err_clr), .timeout_err(timeout_err), .load_count(load_count),
      .fifo_level(fifo_level), .loader_idle(loader_idle)
   );

   always #5 clk = ~clk;

   // Log the address of every distinct write presented to memory.
   always @(negedge clk) begin
      if (mem_we && !we_prev) wq.push_back(mem_addr);
      we_prev = mem_we;
   end

   task automatic push(input logic [11:0] a, input logic [31:0] d);
      host_wr_valid = 1'b1;
      host_wr_addr  = a;
      host_wr_data  = d;
      @(posedge clk); #1;
      host_wr_valid = 1'b0;
   endtask

   task automatic test_reset;
      #2;
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", mem_we); end
      total++; if (mem_addr !== 12'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
      total++; if (mem_din !== 32'h0) begin bad++; $display("FAIL reset_din got=%h exp=0", mem_din); end
      total++; if (load_count !== 16'h0) begin bad++; $display("FAIL reset_count got=%0d exp=0", load_count); end
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", timeout_err); end
      total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
      total++; if (host_wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", host_wr_ready); end
      total++; if (loader_idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", loader_idle); end
      #10 reset = 1'b1;
      @(posedge clk); #1;
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL post_reset_we got=%b exp=0", mem_we); end
   endtask

   task automatic test_single;
      wq.delete();
      push(12'h3B5, 32'h2005_0013);
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL single_we_early got=%b exp=0", mem_we); end
      total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL single_level got=%0d exp=1", fifo_level); end
      @(posedge clk); #1;
      total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL single_we got=%b exp=1", mem_we); end
      total++; if (mem_addr !== 12'h3B5) begin bad++; $display("FAIL single_addr got=%h exp=3b5", mem_addr); end
      total++; if (mem_din !== 32'h2005_0013) begin bad++; $display("FAIL single_din got=%h exp=20050013", mem_din); end
      repeat (2) @(posedge clk); #1;
      total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL single_we_hold got=%b exp=1", mem_we); end
      mem_wr_ack = 1'b1;
      @(posedge clk); #1;
      mem_wr_ack = 1'b0;
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL single_we_drop got=%b exp=0", mem_we); end
      total++; if (load_count !== 16'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", load_count); end
      total++; if (loader_idle !== 1'b1) begin bad++; $display("FAIL single_idle got=%b exp=1", loader_idle); end
      repeat (3) @(posedge clk); #1;
      total++; if (wq.size() !== 1) begin bad++; $display("FAIL single_once got=%0d exp=1", wq.size()); end
      total++; if (mem_addr !== 12'h3B5) begin bad++; $display("FAIL single_addr_hold got=%h exp=3b5", mem_addr); end
   endtask

   task automatic test_full;
      wq.delete();
      mon_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         host_wr_valid = 1'b1;
         host_wr_addr  = 12'h100 + 12'(i);
         host_wr_data  = 32'hA000_0000 + 32'(i);
         @(posedge clk); #1;
         if (i == 3) begin
            total++; if (host_wr_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", host_wr_ready); end
         end
      end
      host_wr_valid = 1'b0;
      total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL full_level got=%0d exp=4", fifo_level); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL full_busy_we got=%b exp=0", mem_we); end
      mem_wr_ack = 1'b1;
      mon_busy = 1'b0;
      repeat (12) @(posedge clk); #1;
      mem_wr_ack = 1'b0;
      total++; if (wq.size() !== 4) begin bad++; $display("FAIL full_writes got=%0d exp=4", wq.size()); end
      else for (int i = 0; i < 4; i++) begin
         total++; if (wq[i] !== 12'h100 + 12'(i)) begin bad++; $display("FAIL full_order[%0d] got=%h exp=%h", i, wq[i], 12'h100 + 12'(i)); end
      end
      total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL full_drain got=%0d exp=0", fifo_level); end
      total++; if (load_count !== 16'd5) begin bad++; $display("FAIL full_count got=%0d exp=5", load_count); end
   endtask

   task automatic test_timeout;
      int cnt = 0;
      push(12'h2AA, 32'hDEAD_BEEF);
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (!mem_we) break;
         cnt++;
      end
      total++; if (cnt !== 255) begin bad++; $display("FAIL tmo_we_cycles got=%0d exp=255", cnt); end
      total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b exp=1", timeout_err); end
      total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL tmo_level got=%0d exp=0", fifo_level); end
      total++; if (load_count !== 16'd5) begin bad++; $display("FAIL tmo_count got=%0d exp=5", load_count); end
      push(12'h2AB, 32'h1);
      repeat (255) @(posedge clk); #1;
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL tmo2_we got=%b exp=0", mem_we); end
      total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_set_dominates got=%b exp=1", timeout_err); end
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b exp=0", timeout_err); end
   endtask

   task automatic test_ack_in_timeout_cycle;
      push(12'h2AC, 32'h2);
      repeat (255) @(posedge clk); #1;
      total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL lateack_we got=%b exp=1", mem_we); end
      mem_wr_ack = 1'b1;
      @(posedge clk); #1;
      mem_wr_ack = 1'b0;
      total++; if (load_count !== 16'd6) begin bad++; $display("FAIL lateack_count got=%0d exp=6", load_count); end
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL lateack_err got=%b exp=0", timeout_err); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL lateack_drop got=%b exp=0", mem_we); end
   endtask

   task automatic test_gating;
      wq.delete();
      mon_busy = 1'b1;
      push(12'h011, 32'h11);
      push(12'h012, 32'h12);
      repeat (4) @(posedge clk); #1;
      total++; if (wq.size() !== 0) begin bad++; $display("FAIL gate_busy_writes got=%0d exp=0", wq.size()); end
      mon_busy = 1'b0;
      for (int i = 0; i < 10 && !mem_we; i++) begin @(posedge clk); #1; end
      total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL gate_start got=%b exp=1", mem_we); end
      mon_busy = 1'b1;
      repeat (2) @(posedge clk); #1;
      total++; if (mem_we !== 1'b1 || mem_addr !== 12'h011) begin bad++; $display("FAIL gate_midwrite got=%b/%h exp=1/011", mem_we, mem_addr); end
      mem_wr_ack = 1'b1;
      @(posedge clk); #1;
      mem_wr_ack = 1'b0;
      repeat (3) @(posedge clk); #1;
      total++; if (mem_we !== 1'b0 || fifo_level !== 3'd1) begin bad++; $display("FAIL gate_hold got=%b/%0d exp=0/1", mem_we, fifo_level); end
      mon_busy = 1'b0;
      for (int i = 0; i < 10; i++) begin @(posedge clk); #1; mem_wr_ack = mem_we; end
      mem_wr_ack = 1'b0;
      total++; if (wq.size() !== 2) begin bad++; $display("FAIL gate_writes got=%0d exp=2", wq.size()); end
      else begin
         total++; if (wq[0] !== 12'h011 || wq[1] !== 12'h012) begin bad++; $display("FAIL gate_order got=%h,%h exp=011,012", wq[0], wq[1]); end
      end
      total++; if (load_count !== 16'd8) begin bad++; $display("FAIL gate_count got=%0d exp=8", load_count); end
   endtask

   task automatic test_reset_mid_write;
      push(12'h021, 32'h21);
      push(12'h022, 32'h22);
      push(12'h023, 32'h23);
      total++; if (mem_we !== 1'b1 || fifo_level !== 3'd3) begin bad++; $display("FAIL rst_pre got=%b/%0d exp=1/3", mem_we, fifo_level); end
      #2 reset = 1'b0;
      #1;
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_async_we got=%b exp=0", mem_we); end
      total++; if (fifo_level !== 3'd0 || load_count !== 16'd0) begin bad++; $display("FAIL rst_async_state got=%0d/%0d exp=0/0", fifo_level, load_count); end
      #3 reset = 1'b1;
      wq.delete();
      repeat (5) @(posedge clk); #1;
      total++; if (wq.size() !== 0 || mem_we !== 1'b0) begin bad++; $display("FAIL rst_no_writes got=%0d/%b exp=0/0", wq.size(), mem_we); end
      push(12'h030, 32'h30);
      for (int i = 0; i < 6; i++) begin @(posedge clk); #1; mem_wr_ack = mem_we; end
      mem_wr_ack = 1'b0;
      total++; if (load_count !== 16'd1 || wq.size() !== 1) begin bad++; $display("FAIL rst_resume got=%0d/%0d exp=1/1", load_count, wq.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_timeout();
      test_ack_in_timeout_cycle();
      test_gating();
      test_reset_mid_write();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
